// File: rtl/valid_array_pkg.sv
// Shared types and helpers for the valid_array storage block.
package valid_array_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

  localparam int unsigned PARITY_MAX_W = 64;

  // Even-parity bit: XOR of all bits, so word plus parity holds an even number of ones.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/flush_sweeper.sv
// Flush sequencer: walks every entry index once, clearing one valid bit per cycle.
module flush_sweeper
  import valid_array_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             clear_en,
  output logic [IDX_W-1:0] clear_idx
);

  sweep_state_t     state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last = (cnt_q == IDX_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        // DEPTH is a power of two, so the increment wraps to 0 on the last entry.
        cnt_d = cnt_q + IDX_W'(1);
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    clear_en  = 1'b0;
    clear_idx = cnt_q;
    if (state_q == SWEEP) begin
      busy     = 1'b1;
      clear_en = 1'b1;
      done     = last;
    end
  end

endmodule

// File: rtl/valid_array.sv
// Parametrised register array with per-entry valid, masked writes, invalidate and flush sweep.
// Optional per-entry even parity when VALID_ARRAY_PARITY_EN is defined.
module valid_array
  import valid_array_pkg::*;
#(
  parameter  int unsigned WIDTH = 1,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] windex,
  input  logic [WIDTH-1:0] datain,
  input  logic [WIDTH-1:0] wmask,
  input  logic             inval,
  input  logic             flush,
  input  logic [IDX_W-1:0] rindex,
  output logic [WIDTH-1:0] dataout,
  output logic             valid_out,
  output logic             busy,
  output logic             done,
  output logic             parity_err
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic                        clear_en;
  logic [IDX_W-1:0]            clear_idx;
  logic                        load_acc, inval_acc, hit;
  logic [WIDTH-1:0]            merged;

  flush_sweeper #(.DEPTH(DEPTH)) u_sweeper (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .clear_en  (clear_en),
    .clear_idx (clear_idx)
  );

  // Writes are dropped while sweeping and in the cycle a flush is accepted.
  assign load_acc  = load & ~busy & ~flush;
  assign inval_acc = inval & ~load & ~busy & ~flush;
  assign hit       = (windex == rindex);
  assign merged    = (data_q[windex] & ~wmask) | (datain & wmask);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_en) valid_d[clear_idx] = 1'b0;
    if (load_acc) begin
      data_d[windex]  = merged;
      valid_d[windex] = 1'b1;
    end else if (inval_acc) begin
      valid_d[windex] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Zero-latency read with write-through of the same-cycle load or invalidate.
  always_comb begin
    dataout   = data_q[rindex];
    valid_out = valid_q[rindex];
    if (load_acc && hit) begin
      dataout   = merged;
      valid_out = 1'b1;
    end else if (inval_acc && hit) begin
      valid_out = 1'b0;
    end
  end

`ifdef VALID_ARRAY_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (load_acc) par_d[windex] = even_parity(PARITY_MAX_W'(merged));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= '0;
    else     par_q <= par_d;
  end

  assign parity_err = valid_out & ~(load_acc & hit) &
                      (even_parity(PARITY_MAX_W'(dataout)) != par_q[rindex]);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/valid_array.md
Name: valid_array

Overview:
- Parametrised successor of the cache's 16-entry register array.
- Generalises width and depth, adds a per-entry valid bit, bit-masked writes, single-entry invalidate, and a multi-cycle flush sweep with busy/done handshake.
- Sits under cache datapath/control as tag, metadata or dirty storage.
- Combinational read with same-cycle write-through bypass, as the existing array.

Parameters:
WIDTH, 1, data bits per entry
DEPTH, 16, number of entries; power of two, >= 2
IDX_W, $clog2(DEPTH), index width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  write enable for entry windex
windex  input  IDX_W  write / invalidate index
datain  input  WIDTH  write data
wmask  input  WIDTH  per-bit write mask, 1 = update bit
inval  input  1  clear valid bit of entry windex
flush  input  1  request clearing of all valid bits
rindex  input  IDX_W  read index
dataout  output  WIDTH  read data
valid_out  output  1  valid bit of read entry
busy  output  1  flush sweep in progress
done  output  1  one-cycle pulse on final sweep cycle
parity_err  output  1  read parity mismatch (see Optional Feature)

Behaviour:
- Reset (async, rst=1): all data words = 0, all valid = 0, FSM = IDLE, sweep counter = 0, busy = 0, done = 0.
- Stored word after write: (old & ~wmask) | (datain & wmask). Load sets valid[windex] = 1.
- Read is combinational, zero latency: dataout = data[rindex], valid_out = valid[rindex].
- Bypass when an accepted load has windex == rindex: dataout = merged word, valid_out = 1.
- Bypass when an accepted inval has windex == rindex (no load): valid_out = 0, dataout = stored data.
- inval: clears valid[windex] only; data untouched. load and inval same cycle: load wins.
- FSM states IDLE, SWEEP.
  - IDLE, flush=1 -> SWEEP. Counter = 0. Load/inval in that cycle are dropped.
  - SWEEP: each cycle clears valid[counter], then counter++. busy = 1 for exactly DEPTH cycles.
  - On counter == DEPTH-1: done = 1 that cycle, counter wraps to 0, next state IDLE.
- During SWEEP:
  - load, inval and flush are ignored; caller must wait for busy = 0.
  - Reads remain legal and return current state: swept entries read valid_out = 0.
  - Data is never cleared by flush.
- rst asserted mid-sweep: immediate return to IDLE, full reset values; no done pulse.
- Out-of-range indices are impossible (DEPTH is a power of two).

Optional Feature:
- Macro VALID_ARRAY_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, computed over the merged word on every write; reset value 0.
  - parity_err = valid_out & (^dataout != stored parity), combinational.
  - Bypassed reads never flag.
- Undefined: no parity storage; parity_err tied 0. Port list is identical in both builds.

Decomposition:
- Package valid_array_pkg holds:
  - enum sweep_state_t {IDLE, SWEEP};
  - the even-parity function.
- One natural sub-module: flush_sweeper (FSM + counter).
  - Outputs busy, done, clear_en, clear_idx.
  - The array core owns storage, mask merge, bypass and parity.

Test Plan:
- Reset then read all indices -> dataout=0, valid_out=0 for DEPTH=16, WIDTH=8.
- Write idx 3 with datain=8'hA5, wmask=8'hFF. Then write datain=8'h0F, wmask=8'h0F. Read idx 3 -> 8'hAF, valid_out=1.
- Same-cycle load idx 5 datain=8'h3C, wmask=8'hF0 (old 8'h00), rindex=5 -> dataout=8'h30 and valid_out=1 in that cycle.
- Fill all 16 entries, pulse flush:
  - busy high 16 cycles, done pulses on 16th cycle;
  - loads issued during busy are not stored;
  - afterwards all valid_out=0 while data is preserved.
- Start flush, assert rst on sweep cycle 7 -> busy=0 immediately, no done, all entries read 0/invalid.
- With VALID_ARRAY_PARITY_EN: write 8'h01 to idx 2, force stored data bit 1 -> parity_err=1 on read idx 2. Without the macro -> parity_err=0.
